// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - multi-cycle fetch/decode/execute/mem/write-back sequencer for the RV32I core
module instruction_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    input  logic        dec_register_write_enable,
    input  logic        dec_memory_write_enable,
    input  logic [1:0]  dec_write_back_select,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        pc_write_enable,
    output logic        rf_write_enable,
    output logic        busy,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] retired_count
);

    localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_CYCLES);
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_FETCH   = 2'b10;
    localparam logic [1:0] CAUSE_DATA    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] wait_count;
    logic [1:0]    cause_reg;
    logic [1:0]    cause_next;
    logic          legal_opcode;
    logic          needs_mem;
    logic          wait_expired;
    logic          waiting;
    logic          ready_now;

    always_comb begin
        legal_opcode = 1'b0;
        case (ir[6:0])
            7'b0110011, 7'b0010011, 7'b1100111, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b0000011, 7'b0100011: legal_opcode = 1'b1;
            default:                                         legal_opcode = 1'b0;
        endcase
    end

    assign needs_mem = (dec_register_write_enable && (dec_write_back_select == 2'b00))
                     || dec_memory_write_enable;

    // Ready is only meaningful in the two wait states; elsewhere it is ignored.
    assign waiting      = (state == S_FETCH) || (state == S_MEM);
    assign ready_now    = (state == S_FETCH) ? imem_ready : dmem_ready;
    assign wait_expired = (TIMEOUT_CYCLES != 0) && (wait_count == TIMEOUT_VAL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        cause_next      = cause_reg;
        imem_req        = 1'b0;
        dmem_req        = 1'b0;
        dmem_we         = 1'b0;
        pc_write_enable = 1'b0;
        rf_write_enable = 1'b0;
        busy            = 1'b1;
        fault           = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (run) state_next = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    state_next = S_DECODE;
                end else if (wait_expired) begin
                    state_next = S_FAULT;
                    cause_next = CAUSE_FETCH;
                end
            end
            S_DECODE: begin
                if (legal_opcode) begin
                    state_next = S_EXEC;
                end else begin
                    state_next = S_FAULT;
                    cause_next = CAUSE_ILLEGAL;
                end
            end
            S_EXEC: begin
                state_next = needs_mem ? S_MEM : S_WB;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_memory_write_enable;
                if (dmem_ready) begin
                    state_next = S_WB;
                end else if (wait_expired) begin
                    state_next = S_FAULT;
                    cause_next = CAUSE_DATA;
                end
            end
            S_WB: begin
                pc_write_enable = 1'b1;
                rf_write_enable = dec_register_write_enable;
                state_next      = run ? S_FETCH : S_IDLE;
            end
            S_FAULT: begin
                busy  = 1'b0;
                fault = 1'b1;
            end
            default: begin
                busy       = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_count <= '0;
        end else if ((state_next != state)
                     && ((state_next == S_FETCH) || (state_next == S_MEM))) begin
            wait_count <= '0;
        end else if ((state_next == state) && (state_next == S_FETCH || state_next == S_MEM)
                     && waiting && !ready_now) begin
            wait_count <= wait_count + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir            <= NOP;
            retired_count <= 32'd0;
            cause_reg     <= CAUSE_NONE;
        end else begin
            cause_reg <= cause_next;
            if ((state == S_FETCH) && imem_ready) begin
                ir <= imem_rdata;
            end
            if (state == S_WB) begin
                retired_count <= retired_count + 32'd1;
            end
        end
    end

    assign fault_cause = (state == S_FAULT) ? cause_reg : CAUSE_NONE;

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - directed self-checking bench for instruction_sequencer
module tb_instruction_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic        dec_register_write_enable;
    logic        dec_memory_write_enable;
    logic [1:0]  dec_write_back_select;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        pc_write_enable;
    logic        rf_write_enable;
    logic        busy;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] retired_count;

    int total = 0;
    int bad   = 0;

    instruction_sequencer #(.TIMEOUT_CYCLES(4)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .run                       (run),
        .imem_req                  (imem_req),
        .imem_ready                (imem_ready),
        .imem_rdata                (imem_rdata),
        .ir                        (ir),
        .dec_register_write_enable (dec_register_write_enable),
        .dec_memory_write_enable   (dec_memory_write_enable),
        .dec_write_back_select     (dec_write_back_select),
        .dmem_req                  (dmem_req),
        .dmem_we                   (dmem_we),
        .dmem_ready                (dmem_ready),
        .pc_write_enable           (pc_write_enable),
        .rf_write_enable           (rf_write_enable),
        .busy                      (busy),
        .fault                     (fault),
        .fault_cause               (fault_cause),
        .retired_count             (retired_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic rwe, input logic mwe, input logic [1:0] wbs);
        dec_register_write_enable = rwe;
        dec_memory_write_enable   = mwe;
        dec_write_back_select     = wbs;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        run = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0; dmem_ready = 1'b0;
        set_dec(1'b0, 1'b0, 2'b00);
        do_reset();

        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_cause", 32'(fault_cause), 32'd0);
        check("rst_ir", ir, 32'h00000013);
        check("rst_retired", retired_count, 32'd0);
        check("rst_pc_we", 32'(pc_write_enable), 32'd0);

        // addi x1,x0,5 with zero-wait fetch
        run = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h00500093;
        set_dec(1'b1, 1'b0, 2'b01);
        step();
        check("addi_c1_imem_req", 32'(imem_req), 32'd1);
        check("addi_c1_busy", 32'(busy), 32'd1);
        step();
        check("addi_c2_imem_req", 32'(imem_req), 32'd0);
        check("addi_c2_ir", ir, 32'h00500093);
        step();
        check("addi_c3_pc_we", 32'(pc_write_enable), 32'd0);
        check("addi_c3_rf_we", 32'(rf_write_enable), 32'd0);
        step();
        check("addi_c4_pc_we", 32'(pc_write_enable), 32'd1);
        check("addi_c4_rf_we", 32'(rf_write_enable), 32'd1);
        step();
        check("addi_c5_imem_req", 32'(imem_req), 32'd1);
        check("addi_c5_pc_we", 32'(pc_write_enable), 32'd0);
        check("addi_c5_retired", retired_count, 32'd1);
        run = 1'b0;
        step(); step(); step();
        check("addi2_wb_pc_we", 32'(pc_write_enable), 32'd1);
        step();
        check("addi2_idle_busy", 32'(busy), 32'd0);
        check("addi2_retired", retired_count, 32'd2);

        // sw with three wait cycles on the data port
        run = 1'b1; imem_rdata = 32'h00112023;
        set_dec(1'b0, 1'b1, 2'b00);
        step();
        run = 1'b0;
        step(); step();
        step();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("sw_mem%0d_req", i), 32'(dmem_req), 32'd1);
            check($sformatf("sw_mem%0d_we", i), 32'(dmem_we), 32'd1);
            check($sformatf("sw_mem%0d_rf_we", i), 32'(rf_write_enable), 32'd0);
            if (i == 3) dmem_ready = 1'b1;
            step();
        end
        dmem_ready = 1'b0;
        check("sw_wb_pc_we", 32'(pc_write_enable), 32'd1);
        check("sw_wb_rf_we", 32'(rf_write_enable), 32'd0);
        check("sw_wb_dmem_we", 32'(dmem_we), 32'd0);
        step();
        check("sw_retired", retired_count, 32'd3);
        check("sw_idle_busy", 32'(busy), 32'd0);

        // illegal opcode
        run = 1'b1; imem_rdata = 32'h0000007F;
        set_dec(1'b1, 1'b0, 2'b01);
        step();
        run = 1'b0;
        step();
        check("ill_decode_busy", 32'(busy), 32'd1);
        step();
        check("ill_fault", 32'(fault), 32'd1);
        check("ill_cause", 32'(fault_cause), 32'd1);
        check("ill_busy", 32'(busy), 32'd0);
        check("ill_pc_we", 32'(pc_write_enable), 32'd0);
        run = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("ill_sticky_fault", 32'(fault), 32'd1);
        check("ill_sticky_imem_req", 32'(imem_req), 32'd0);
        check("ill_sticky_ir", ir, 32'h0000007F);
        check("ill_sticky_retired", retired_count, 32'd3);
        run = 1'b0;
        do_reset();
        check("ill_rst_fault", 32'(fault), 32'd0);
        check("ill_rst_cause", 32'(fault_cause), 32'd0);

        // fetch timeout with TIMEOUT_CYCLES=4
        imem_ready = 1'b0; imem_rdata = 32'h00500093;
        run = 1'b1;
        step();
        run = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            check($sformatf("fto_c%0d_imem_req", i), 32'(imem_req), 32'd1);
            if (i < 5) step();
        end
        step();
        check("fto_fault", 32'(fault), 32'd1);
        check("fto_cause", 32'(fault_cause), 32'd2);
        check("fto_imem_req", 32'(imem_req), 32'd0);
        do_reset();

        // ready arrives on the 5th fetch cycle: ready wins
        run = 1'b1;
        step();
        run = 1'b0;
        for (int i = 1; i < 5; i++) step();
        imem_ready = 1'b1;
        check("frdy_c5_imem_req", 32'(imem_req), 32'd1);
        step();
        check("frdy_fault", 32'(fault), 32'd0);
        check("frdy_imem_req", 32'(imem_req), 32'd0);
        check("frdy_busy", 32'(busy), 32'd1);
        check("frdy_ir", ir, 32'h00500093);
        step(); step();
        check("frdy_wb_pc_we", 32'(pc_write_enable), 32'd1);
        step();
        check("frdy_retired", retired_count, 32'd1);

        // load with run dropped in EXEC
        imem_rdata = 32'h0000A083; dmem_ready = 1'b1;
        set_dec(1'b1, 1'b0, 2'b00);
        run = 1'b1;
        step(); step(); step();
        run = 1'b0;
        step();
        check("lw_mem_req", 32'(dmem_req), 32'd1);
        check("lw_mem_we", 32'(dmem_we), 32'd0);
        check("lw_mem_rf_we", 32'(rf_write_enable), 32'd0);
        step();
        check("lw_wb_rf_we", 32'(rf_write_enable), 32'd1);
        check("lw_wb_pc_we", 32'(pc_write_enable), 32'd1);
        step();
        check("lw_idle_busy", 32'(busy), 32'd0);
        check("lw_idle_imem_req", 32'(imem_req), 32'd0);
        check("lw_retired", retired_count, 32'd2);
        run = 1'b1;
        step();
        check("lw_rerun_imem_req", 32'(imem_req), 32'd1);
        run = 1'b0;

        // reset while in MEM
        dmem_ready = 1'b0;
        step(); step(); step();
        check("rmem_dmem_req", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        step();
        check("rmem_dmem_req_after", 32'(dmem_req), 32'd0);
        check("rmem_busy", 32'(busy), 32'd0);
        check("rmem_pc_we", 32'(pc_write_enable), 32'd0);
        check("rmem_retired", retired_count, 32'd0);
        check("rmem_ir", ir, 32'h00000013);
        rst = 1'b0;

        // data timeout
        imem_ready = 1'b1; imem_rdata = 32'h0000A083;
        run = 1'b1;
        step();
        run = 1'b0;
        step(); step();
        for (int i = 0; i < 5; i++) step();
        check("dto_last_mem_req", 32'(dmem_req), 32'd1);
        step();
        check("dto_fault", 32'(fault), 32'd1);
        check("dto_cause", 32'(fault_cause), 32'd3);
        check("dto_dmem_req", 32'(dmem_req), 32'd0);
        check("dto_retired", retired_count, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
